axis_fft_frame_feeder: RTL and testbench
========================================

Name: axis_fft_frame_feeder

Overview:
- Synthesisable AXI-Stream frame source that drives the FFT core's config and data slave channels.
- Holds one frame of complex samples in an internal sample RAM, loaded by a simple write port.
- After start, issues one config word, then streams a programmable number of N-point frames, marking the last sample of each frame with tlast.
- Honours backpressure; supports continuous mode and a graceful stop.

Parameters:
- DATA_W, 32, sample width (imag in [DATA_W-1:DATA_W/2], real in [DATA_W/2-1:0])
- MAX_LOG2, 10, log2 of the largest frame length and the RAM depth (1024)
- CFG_W, 8, FFT config word width

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- aclken  in  1  clock enable; when low, all state and outputs hold
- ld_wr_en  in  1  sample RAM write strobe
- ld_addr  in  MAX_LOG2  sample RAM write address
- ld_data  in  DATA_W  sample RAM write data
- nfft_log2  in  4  frame length N = 2^nfft_log2; sampled at start
- frame_count  in  16  frames to send, 0 = continuous; sampled at start
- cfg_word  in  CFG_W  config word, e.g. 8'h01 for forward; sampled at start
- start  in  1  single-cycle start pulse
- stop  in  1  pulse; finish the current frame, then end
- m_axis_config_tdata  out  CFG_W  config word
- m_axis_config_tvalid  out  1  config valid
- m_axis_config_tready  in  1  config ready
- m_axis_data_tdata  out  DATA_W  sample
- m_axis_data_tvalid  out  1  sample valid
- m_axis_data_tready  in  1  sample ready
- m_axis_data_tlast  out  1  last sample of frame
- busy  out  1  high from START accepted until DONE
- done  out  1  one-cycle pulse at end of run
- frames_sent  out  16  completed-frame counter, wraps at 2^16

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. RAM contents are undefined after reset and are not cleared.
- Reset mid-operation: tvalid drops immediately (asynchronously), state returns to IDLE, and no done pulse is generated.
- aclken low: every register, including RAM read and write, holds. Handshakes are evaluated only on cycles where aclken is high.
- nfft_log2 range handling:
  - values below 3 clamp to 3
  - values above MAX_LOG2 clamp to MAX_LOG2
  - the clamped value is latched at start
- FSM states: IDLE, CFG, PRIME, STREAM, DONE.
- IDLE:
  - start -> CFG; latch nfft_log2, frame_count and cfg_word; busy goes high on the next cycle.
  - stop in IDLE is ignored.
- CFG:
  - m_axis_config_tvalid = 1, tdata = latched cfg_word.
  - On tvalid && tready -> PRIME; config tvalid deasserts in the same edge.
- PRIME: issue a RAM read of address 0; next state is STREAM. The RAM has 1-cycle read latency.
- STREAM, output register plus one-entry prefetch:
  - m_axis_data_tvalid is held high continuously; no bubbles while tready stays high.
  - First tvalid appears 2 cycles after the config handshake.
  - A sample address advances only on tvalid && tready.
  - tdata and tlast are stable while tvalid && !tready.
  - tlast = 1 exactly when the sample index equals N-1.
  - After index N-1 the index wraps to 0, and frames_sent increments on the tlast handshake.
- End of run, evaluated on the tlast handshake:
  - if frame_count != 0 and frames completed in this run == frame_count -> DONE
  - if a stop was seen at any time during this run -> DONE
  - otherwise continue at index 0 with no gap
  - stop is registered as a sticky flag and never truncates a frame.
- DONE: one cycle; done = 1, busy drops, then -> IDLE.
- start while busy is ignored.
- ld_wr_en while busy is ignored, so the RAM is write-protected during a run.
- A write in the same cycle as an accepted start is performed.
- Simultaneous stop and start in IDLE: start is accepted and stop is discarded.
- frames_sent clears on an accepted start, not at DONE.

Decomposition:
- Shared package axis_feeder_pkg holds:
  - the FSM state enum
  - MIN_LOG2 = 3
  - the default config word constants CFG_FWD = 8'h01 and CFG_INV = 8'h00
- One sub-module, feeder_sample_ram: simple dual-port, 2^MAX_LOG2 x DATA_W, synchronous write, 1-cycle registered read, with the read enable gated by aclken.

Test Plan:
- Load ramp samples 0..7; nfft_log2 = 3, frame_count = 2, cfg_word = 8'h01; tready held high.
  -> one config beat of 8'h01, then 16 data beats 0..7, 0..7 with no gaps; tlast on beats 8 and 16; done pulse; frames_sent = 2.
- Same setup, with data tready toggling 1-0-1-0.
  -> identical sample sequence; tdata and tlast stable during every stalled cycle; the tlast count is still 2.
- config tready held low for 5 cycles after start.
  -> config tvalid stays high with tdata = 8'h01; no data tvalid until 2 cycles after the config handshake.
- frame_count = 0 with N = 1024 (1024-sample sine loaded); pulse stop at sample 300 of frame 3.
  -> frame 3 completes through index 1023 with tlast; done pulses; frames_sent = 3 (counting from 1).
- Assert aresetn low at sample 5 of a run.
  -> tvalid, busy and tlast go to 0 immediately; no done pulse; a subsequent start replays from config with samples still intact.
- Set nfft_log2 = 1 and frame_count = 1, and issue start and a ld_wr_en write while busy.
  -> frame length is 8 (clamped); tlast appears on beat 8; the second start is ignored and RAM is unchanged.

Source files
------------

// File: rtl/axis_feeder_pkg.sv
// ---------------------------------------------------------------------------
// axis_feeder_pkg
// Shared definitions for the AXI-Stream FFT frame feeder:
//   feeder_state_t : run-control FSM states
//   MIN_LOG2       : smallest supported frame length exponent (N = 8)
//   CFG_FWD/CFG_INV: FFT config words for forward / inverse transforms
// ---------------------------------------------------------------------------
package axis_feeder_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CFG    = 3'd1,
      S_PRIME  = 3'd2,
      S_STREAM = 3'd3,
      S_DONE   = 3'd4
   } feeder_state_t;

   localparam int         MIN_LOG2 = 3;
   localparam logic [7:0] CFG_FWD  = 8'h01;
   localparam logic [7:0] CFG_INV  = 8'h00;

endpackage

// File: rtl/feeder_sample_ram.sv
// ---------------------------------------------------------------------------
// feeder_sample_ram
// Simple dual-port sample store, 2^ADDR_W x DATA_W. Synchronous write,
// registered read with one cycle of latency. Both ports are qualified by the
// clock enable so the whole memory freezes when ce is low. Contents are not
// reset.
//   clk      : clock
//   ce       : clock enable for both ports
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data holds its value when low
//   rd_addr  : read address
//   rd_data  : registered read data
// ---------------------------------------------------------------------------
module feeder_sample_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              ce,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (ce) begin
         if (wr_en) mem[wr_addr] <= wr_data;
         if (rd_en) rd_data      <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axis_fft_frame_feeder.sv
// ---------------------------------------------------------------------------
// axis_fft_frame_feeder
// AXI-Stream frame source for an FFT core. A run sends one config beat, then
// repeats the stored N-point frame (N = 2^nfft_log2, clamped to 8..2^MAX_LOG2)
// either frame_count times or, when frame_count is 0, until stop is seen.
// tlast marks the last sample of every frame; a stop never truncates a frame.
//   aclk, aresetn, aclken         : clock, async active-low reset, clock enable
//   ld_wr_en/ld_addr/ld_data      : sample RAM load port (ignored while busy)
//   nfft_log2, frame_count,
//   cfg_word                      : run settings, latched on start
//   start, stop                   : run control pulses
//   m_axis_config_*               : config master channel
//   m_axis_data_*                 : sample master channel
//   busy, done, frames_sent       : run status
// ---------------------------------------------------------------------------
module axis_fft_frame_feeder
   import axis_feeder_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MAX_LOG2 = 10,
   parameter int CFG_W    = 8
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                aclken,
   input  logic                ld_wr_en,
   input  logic [MAX_LOG2-1:0] ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic [3:0]          nfft_log2,
   input  logic [15:0]         frame_count,
   input  logic [CFG_W-1:0]    cfg_word,
   input  logic                start,
   input  logic                stop,
   output logic [CFG_W-1:0]    m_axis_config_tdata,
   output logic                m_axis_config_tvalid,
   input  logic                m_axis_config_tready,
   output logic [DATA_W-1:0]   m_axis_data_tdata,
   output logic                m_axis_data_tvalid,
   input  logic                m_axis_data_tready,
   output logic                m_axis_data_tlast,
   output logic                busy,
   output logic                done,
   output logic [15:0]         frames_sent
);

   function automatic logic [3:0] clamp_log2(input logic [3:0] l2);
      if (l2 < 4'(MIN_LOG2))      return 4'(MIN_LOG2);
      else if (l2 > 4'(MAX_LOG2)) return 4'(MAX_LOG2);
      else                        return l2;
   endfunction

   // Index mask N-1 for N = 2^l2; also the index of the last sample.
   function automatic logic [MAX_LOG2-1:0] len_mask(input logic [3:0] l2);
      logic [MAX_LOG2-1:0] m;
      for (int i = 0; i < MAX_LOG2; i++) m[i] = (i < int'(l2));
      return m;
   endfunction

   feeder_state_t       state;
   logic [CFG_W-1:0]    cfg_q;
   logic                cfg_vld;
   logic [15:0]         frame_count_q;
   logic [MAX_LOG2-1:0] mask_q;
   logic                stop_seen;
   logic                busy_q;
   logic                done_q;
   logic [15:0]         frames_q;

   logic [MAX_LOG2-1:0] rd_idx_p0;
   logic [DATA_W-1:0]   ram_q_p0;
   logic [DATA_W-1:0]   data_p1;
   logic                last_p1;
   logic                vld_p1;

   logic                data_hs;
   logic                last_hs;
   logic                advance;
   logic                run_end;
   logic [MAX_LOG2-1:0] idx_next;
   logic                rd_en;
   logic [MAX_LOG2-1:0] rd_addr;
   logic                wr_en;

   assign idx_next = (rd_idx_p0 + 1'b1) & mask_q;
   assign data_hs  = vld_p1 & m_axis_data_tready;
   assign last_hs  = data_hs & last_p1;
   // The output register refills whenever it is empty or being drained.
   assign advance  = (state == S_STREAM) & (~vld_p1 | data_hs);
   // A stop arriving on the final handshake still counts as seen in this run.
   assign run_end  = last_hs &
                     (((frame_count_q != 16'd0) && (frames_q + 16'd1 == frame_count_q)) ||
                      stop_seen || stop);
   assign rd_en    = (state == S_PRIME) | (advance & ~run_end);
   assign rd_addr  = (state == S_PRIME) ? '0 : idx_next;
   assign wr_en    = ld_wr_en & ~busy_q;

   // Stage p0: RAM read register doubles as the one-entry prefetch.
   feeder_sample_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (MAX_LOG2)
   ) u_ram (
      .clk     (aclk),
      .ce      (aclken),
      .wr_en   (wr_en),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_q_p0)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= S_IDLE;
         cfg_q         <= '0;
         cfg_vld       <= 1'b0;
         frame_count_q <= '0;
         mask_q        <= '0;
         stop_seen     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         frames_q      <= '0;
         rd_idx_p0     <= '0;
         data_p1       <= '0;
         last_p1       <= 1'b0;
         vld_p1        <= 1'b0;
      end else if (aclken) begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state         <= S_CFG;
                  cfg_q         <= cfg_word;
                  frame_count_q <= frame_count;
                  mask_q        <= len_mask(clamp_log2(nfft_log2));
                  frames_q      <= '0;
                  stop_seen     <= 1'b0;
                  busy_q        <= 1'b1;
                  cfg_vld       <= 1'b1;
               end
            end
            S_CFG: begin
               if (stop) stop_seen <= 1'b1;
               if (m_axis_config_tready) begin
                  cfg_vld <= 1'b0;
                  state   <= S_PRIME;
               end
            end
            S_PRIME: begin
               if (stop) stop_seen <= 1'b1;
               rd_idx_p0 <= '0;
               state     <= S_STREAM;
            end
            S_STREAM: begin
               if (stop)    stop_seen <= 1'b1;
               if (last_hs) frames_q  <= frames_q + 16'd1;
               if (run_end) begin
                  vld_p1  <= 1'b0;
                  last_p1 <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= S_DONE;
               end else if (advance) begin
                  // Stage p1: move the prefetched sample into the output register.
                  data_p1   <= ram_q_p0;
                  last_p1   <= (rd_idx_p0 == mask_q);
                  vld_p1    <= 1'b1;
                  rd_idx_p0 <= idx_next;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign m_axis_config_tdata  = cfg_q;
   assign m_axis_config_tvalid = cfg_vld;
   assign m_axis_data_tdata    = data_p1;
   assign m_axis_data_tvalid   = vld_p1;
   assign m_axis_data_tlast    = last_p1;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign frames_sent          = frames_q;

endmodule

// File: tb/tb_axis_fft_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_axis_fft_frame_feeder
// Table-driven bench for axis_fft_frame_feeder: each record describes one run
// (settings, ready pattern, stop placement) with hand-computed frame length,
// beat, tlast and frame counts. Sample values come from a shadow copy of the
// RAM contents written by the bench. Reset behaviour is exercised by hand.
// ---------------------------------------------------------------------------
module tb_axis_fft_frame_feeder;
   import axis_feeder_pkg::*;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        aclken;
   logic        ld_wr_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;
   logic [3:0]  nfft_log2;
   logic [15:0] frame_count;
   logic [7:0]  cfg_word;
   logic        start;
   logic        stop;
   logic [7:0]  m_axis_config_tdata;
   logic        m_axis_config_tvalid;
   logic        m_axis_config_tready;
   logic [31:0] m_axis_data_tdata;
   logic        m_axis_data_tvalid;
   logic        m_axis_data_tready;
   logic        m_axis_data_tlast;
   logic        busy;
   logic        done;
   logic [15:0] frames_sent;

   always #5 aclk = ~aclk;

   axis_fft_frame_feeder dut (
      .aclk                 (aclk),
      .aresetn              (aresetn),
      .aclken               (aclken),
      .ld_wr_en             (ld_wr_en),
      .ld_addr              (ld_addr),
      .ld_data              (ld_data),
      .nfft_log2            (nfft_log2),
      .frame_count          (frame_count),
      .cfg_word             (cfg_word),
      .start                (start),
      .stop                 (stop),
      .m_axis_config_tdata  (m_axis_config_tdata),
      .m_axis_config_tvalid (m_axis_config_tvalid),
      .m_axis_config_tready (m_axis_config_tready),
      .m_axis_data_tdata    (m_axis_data_tdata),
      .m_axis_data_tvalid   (m_axis_data_tvalid),
      .m_axis_data_tready   (m_axis_data_tready),
      .m_axis_data_tlast    (m_axis_data_tlast),
      .busy                 (busy),
      .done                 (done),
      .frames_sent          (frames_sent)
   );

   typedef struct {
      logic [3:0]  l2;
      logic [15:0] fc;
      logic [7:0]  cfg;
      int          pat;        // 0 ramp, 1 sine
      int          rmode;      // 0 ready always high, 1 ready toggling
      bit          ce_gap;     // aclken low every third cycle while streaming
      int          cfg_hold;   // cycles config tready is held low
      bit          poke;       // second start + RAM write while busy
      int          stop_mode;  // 0 none, 1 with start, 2 at beat stop_at
      int          stop_at;
      int          exp_len;
      int          exp_beats;
      int          exp_lasts;
      int          exp_frames;
   } vec_t;

   logic [31:0] ram_m [0:1023];
   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load_ram(input int pat);
      int n;
      int re, im;
      logic [31:0] w;
      n = (pat == 0) ? 16 : 1024;
      for (int i = 0; i < n; i++) begin
         if (pat == 0) begin
            w = 32'(i);
         end else begin
            re = int'(1000.0 * $cos(2.0 * 3.14159265358979 * i / 1024.0));
            im = int'(1000.0 * $sin(2.0 * 3.14159265358979 * i / 1024.0));
            w  = {16'(im), 16'(re)};
         end
         @(negedge aclk);
         ld_wr_en = 1'b1;
         ld_addr  = 10'(i);
         ld_data  = w;
         ram_m[i] = w;
      end
      @(negedge aclk);
      ld_wr_en = 1'b0;
   endtask

   task automatic do_run(input vec_t v, input int id);
      int beats, lasts, gaps, cyc, mask;
      bit got_done, prev_stall, stop_done;
      logic [31:0] pd;
      logic pl;
      string p;
      p = $sformatf("v%0d", id);
      mask = v.exp_len - 1;
      beats = 0; lasts = 0; gaps = 0; cyc = 0;
      got_done = 0; prev_stall = 0; stop_done = 0;
      pd = '0; pl = 1'b0;

      @(negedge aclk);
      nfft_log2   = v.l2;
      frame_count = v.fc;
      cfg_word    = v.cfg;
      aclken      = 1'b1;
      start       = 1'b1;
      stop        = (v.stop_mode == 1);
      @(negedge aclk);
      start = 1'b0;
      stop  = 1'b0;
      check({p, "_busy_after_start"}, busy, 1);
      check({p, "_frames_cleared"}, frames_sent, 0);

      // config phase
      for (int h = 0; h < v.cfg_hold; h++) begin
         check({p, "_cfg_hold_valid"}, m_axis_config_tvalid, 1);
         check({p, "_cfg_hold_data"}, m_axis_config_tdata, v.cfg);
         check({p, "_no_data_in_cfg"}, m_axis_data_tvalid, 0);
         if (v.poke && h == 0) begin
            start    = 1'b1;
            ld_wr_en = 1'b1;
            ld_addr  = 10'd2;
            ld_data  = 32'hDEAD_BEEF;
         end
         @(negedge aclk);
         start    = 1'b0;
         ld_wr_en = 1'b0;
      end
      check({p, "_cfg_valid"}, m_axis_config_tvalid, 1);
      check({p, "_cfg_data"}, m_axis_config_tdata, v.cfg);
      m_axis_config_tready = 1'b1;
      @(negedge aclk);
      m_axis_config_tready = 1'b0;
      check({p, "_cfg_dropped"}, m_axis_config_tvalid, 0);
      check({p, "_lat_c1"}, m_axis_data_tvalid, 0);
      @(negedge aclk);
      check({p, "_lat_c2"}, m_axis_data_tvalid, 0);
      @(negedge aclk);
      check({p, "_first_valid"}, m_axis_data_tvalid, 1);

      // streaming phase
      while (!got_done && cyc < 4 * v.exp_beats + 64) begin
         m_axis_data_tready = (v.rmode == 0) ? 1'b1 : ((cyc % 2) == 0);
         aclken = v.ce_gap ? ((cyc % 3) != 2) : 1'b1;
         stop = (v.stop_mode == 2 && beats == v.stop_at && !stop_done);
         if (stop) stop_done = 1;
         if (done) begin
            got_done = 1;
            check({p, "_busy_at_done"}, busy, 0);
            check({p, "_valid_at_done"}, m_axis_data_tvalid, 0);
         end else begin
            if (!m_axis_data_tvalid) begin
               if (beats < v.exp_beats) gaps++;
            end else begin
               if (prev_stall) begin
                  check({p, "_stall_data"}, m_axis_data_tdata, pd);
                  check({p, "_stall_last"}, m_axis_data_tlast, pl);
               end
               if (aclken && m_axis_data_tready) begin
                  check($sformatf("%s_data_b%0d", p, beats), m_axis_data_tdata, ram_m[beats & mask]);
                  check($sformatf("%s_last_b%0d", p, beats), m_axis_data_tlast, ((beats & mask) == mask));
                  if (m_axis_data_tlast) lasts++;
                  beats++;
                  prev_stall = 0;
               end else begin
                  prev_stall = 1;
                  pd = m_axis_data_tdata;
                  pl = m_axis_data_tlast;
               end
            end
            @(negedge aclk);
            cyc++;
         end
      end
      stop   = 1'b0;
      aclken = 1'b1;
      m_axis_data_tready = 1'b0;
      check({p, "_done_seen"}, got_done, 1);
      check({p, "_beats"}, beats, v.exp_beats);
      check({p, "_tlasts"}, lasts, v.exp_lasts);
      check({p, "_frames_sent"}, frames_sent, v.exp_frames);
      check({p, "_no_gaps"}, gaps, 0);
      @(negedge aclk);
      check({p, "_done_one_cycle"}, done, 0);
      check({p, "_idle_busy"}, busy, 0);
   endtask

   vec_t vecs[11];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur_pat;
      int beats, cyc, dones;
      vec_t rv;

      //             l2     fc      cfg      pat rm ce   hold poke sm  at    len   beats lasts frames
      vecs[0]  = '{4'd3,  16'd2, CFG_FWD, 0, 0, 1'b0, 0, 1'b0, 0, 0,    8,    16,   2, 2};
      vecs[1]  = '{4'd3,  16'd2, CFG_FWD, 0, 1, 1'b0, 0, 1'b0, 0, 0,    8,    16,   2, 2};
      vecs[2]  = '{4'd3,  16'd1, CFG_INV, 0, 0, 1'b0, 5, 1'b0, 0, 0,    8,    8,    1, 1};
      vecs[3]  = '{4'd1,  16'd1, CFG_FWD, 0, 0, 1'b0, 2, 1'b1, 0, 0,    8,    8,    1, 1};
      vecs[4]  = '{4'd4,  16'd1, 8'hA5,   0, 1, 1'b1, 0, 1'b0, 0, 0,    16,   16,   1, 1};
      vecs[5]  = '{4'd3,  16'd3, CFG_FWD, 0, 0, 1'b0, 0, 1'b0, 1, 0,    8,    24,   3, 3};
      vecs[6]  = '{4'd3,  16'd5, CFG_FWD, 0, 0, 1'b0, 0, 1'b0, 2, 10,   8,    16,   2, 2};
      vecs[7]  = '{4'd3,  16'd0, CFG_FWD, 0, 1, 1'b0, 0, 1'b0, 2, 3,    8,    8,    1, 1};
      vecs[8]  = '{4'd10, 16'd0, CFG_FWD, 1, 0, 1'b0, 0, 1'b0, 2, 2348, 1024, 3072, 3, 3};
      vecs[9]  = '{4'd13, 16'd1, CFG_FWD, 1, 0, 1'b0, 0, 1'b0, 0, 0,    1024, 1024, 1, 1};
      vecs[10] = '{4'd0,  16'd1, CFG_FWD, 1, 0, 1'b0, 0, 1'b0, 0, 0,    8,    8,    1, 1};

      aresetn = 1'b0; aclken = 1'b1; ld_wr_en = 1'b0; ld_addr = '0; ld_data = '0;
      nfft_log2 = '0; frame_count = '0; cfg_word = '0; start = 1'b0; stop = 1'b0;
      m_axis_config_tready = 1'b0; m_axis_data_tready = 1'b0;

      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      check("rst_data_valid", m_axis_data_tvalid, 0);
      check("rst_cfg_valid", m_axis_config_tvalid, 0);
      check("rst_data", m_axis_data_tdata, 0);
      check("rst_cfg_data", m_axis_config_tdata, 0);
      check("rst_last", m_axis_data_tlast, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_frames", frames_sent, 0);

      load_ram(0);
      cur_pat = 0;

      // stop while idle must not leak into the next run
      @(negedge aclk); stop = 1'b1;
      @(negedge aclk); stop = 1'b0;
      check("idle_stop_busy", busy, 0);

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].pat != cur_pat) begin
            load_ram(vecs[i].pat);
            cur_pat = vecs[i].pat;
         end
         do_run(vecs[i], i);
      end

      // reset in the middle of a continuous run
      nfft_log2 = 4'd3; frame_count = 16'd0; cfg_word = CFG_FWD;
      m_axis_config_tready = 1'b1; m_axis_data_tready = 1'b1;
      @(negedge aclk); start = 1'b1;
      @(negedge aclk); start = 1'b0;
      beats = 0; cyc = 0;
      while (beats < 5 && cyc < 100) begin
         if (m_axis_data_tvalid) beats++;
         @(negedge aclk);
         cyc++;
      end
      check("mid_reached_5", beats, 5);
      check("mid_valid_before_rst", m_axis_data_tvalid, 1);
      aresetn = 1'b0;
      #1;
      check("mid_rst_valid", m_axis_data_tvalid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_last", m_axis_data_tlast, 0);
      check("mid_rst_frames", frames_sent, 0);
      m_axis_config_tready = 1'b0; m_axis_data_tready = 1'b0;
      dones = 0;
      repeat (2) begin
         @(negedge aclk);
         if (done) dones++;
      end
      aresetn = 1'b1;
      repeat (4) begin
         @(negedge aclk);
         if (done) dones++;
      end
      check("mid_rst_no_done", dones, 0);
      check("mid_rst_idle_busy", busy, 0);

      rv = '{4'd3, 16'd1, CFG_FWD, 1, 0, 1'b0, 0, 1'b0, 0, 0, 8, 8, 1, 1};
      do_run(rv, 99);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
